// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one data memory between the CPU control FSM and a DMA/IO requester
// Optional build macro CPU_PRIORITY_EN: when defined, cpu_req always beats dma_req
// (last winner is still tracked); when undefined, ties are resolved round-robin.
module mem_arbiter #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_ack,
  output logic [DW-1:0] dma_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rd,
  output logic          mem_wr,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  // Counter reload: strobes stay up for MEM_LAT cycles, counting MEM_LAT-1 down to 0.
  localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

  state_t          state, state_n;
  logic [3:0]      cnt, cnt_n;
  logic            last_winner, last_winner_n;
  logic            win;
  logic            win_we;
  logic            cpu_ack_n, dma_ack_n, mem_rd_n, mem_wr_n, busy_n, owner_n;
  logic [DW-1:0]   cpu_rdata_n, dma_rdata_n, mem_wdata_n;
  logic [AW-1:0]   mem_addr_n;

  // Winner selection among the requesters present this cycle (0=CPU, 1=DMA).
  always_comb begin
`ifdef CPU_PRIORITY_EN
    win = ~cpu_req;
`else
    if (cpu_req && dma_req) begin
      win = ~last_winner;
    end else begin
      win = ~cpu_req;
    end
`endif
    win_we = win ? dma_we : cpu_we;
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    last_winner_n = last_winner;
    cpu_ack_n     = cpu_ack;
    dma_ack_n     = dma_ack;
    cpu_rdata_n   = cpu_rdata;
    dma_rdata_n   = dma_rdata;
    mem_addr_n    = mem_addr;
    mem_wdata_n   = mem_wdata;
    mem_rd_n      = mem_rd;
    mem_wr_n      = mem_wr;
    busy_n        = busy;
    owner_n       = owner;
    case (state)
      IDLE: begin
        if (cpu_req || dma_req) begin
          owner_n     = win;
          busy_n      = 1'b1;
          mem_addr_n  = win ? dma_addr : cpu_addr;
          mem_wdata_n = win ? dma_wdata : cpu_wdata;
          mem_rd_n    = ~win_we;
          mem_wr_n    = win_we;
          cnt_n       = CNT_LOAD;
          state_n     = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt != 4'd0) begin
          cnt_n = cnt - 4'd1;
        end else begin
          // Last strobe cycle: memory data is valid now, so capture it for reads.
          if (mem_rd) begin
            if (owner) dma_rdata_n = mem_rdata;
            else       cpu_rdata_n = mem_rdata;
          end
          mem_rd_n = 1'b0;
          mem_wr_n = 1'b0;
          if (owner) dma_ack_n = 1'b1;
          else       cpu_ack_n = 1'b1;
          state_n  = DONE;
        end
      end
      DONE: begin
        cpu_ack_n     = 1'b0;
        dma_ack_n     = 1'b0;
        last_winner_n = owner;
        busy_n        = 1'b0;
        state_n       = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and output registers; reset lets the CPU win the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      last_winner <= 1'b1;
      cpu_ack     <= 1'b0;
      dma_ack     <= 1'b0;
      cpu_rdata   <= '0;
      dma_rdata   <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
      busy        <= 1'b0;
      owner       <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      last_winner <= last_winner_n;
      cpu_ack     <= cpu_ack_n;
      dma_ack     <= dma_ack_n;
      cpu_rdata   <= cpu_rdata_n;
      dma_rdata   <= dma_rdata_n;
      mem_addr    <= mem_addr_n;
      mem_wdata   <= mem_wdata_n;
      mem_rd      <= mem_rd_n;
      mem_wr      <= mem_wr_n;
      busy        <= busy_n;
      owner       <= owner_n;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter
module tb_mem_arbiter;
  localparam int L = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       req [2];
  logic       we  [2];
  logic [7:0] addr[2];
  logic [7:0] wd  [2];
  logic       cpu_ack, dma_ack, mem_rd, mem_wr, busy, owner;
  logic [7:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;

  mem_arbiter #(.AW(8), .DW(8), .MEM_LAT(L)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(req[0]), .cpu_we(we[0]), .cpu_addr(addr[0]), .cpu_wdata(wd[0]),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(req[1]), .dma_we(we[1]), .dma_addr(addr[1]), .dma_wdata(wd[1]),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  // Memory array behind the arbiter; unwritten locations read as addr^0xB5.
  bit [7:0] mem [256];
  bit       seen[256];
  always @(posedge clk) begin
    if (mem_wr) begin
      mem[mem_addr]  <= mem_wdata;
      seen[mem_addr] <= 1'b1;
    end
  end
  assign mem_rdata = seen[mem_addr] ? mem[mem_addr] : (mem_addr ^ 8'hB5);

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Transaction-level reference: a grant at edge g gives strobes after edges g..g+L-1,
  // ack after edge g+L, idle after g+L+1, next grant no earlier than edge g+L+2.
  bit [7:0] ref_mem[256];
  int       e = 0;
  int       m_g = 0;
  bit       m_act = 0, m_win = 0, m_we = 0, m_last = 1, m_owner = 0;
  bit [7:0] m_maddr = 0, m_mwd = 0, m_crd = 0, m_drd = 0, m_rexp = 0;
  bit       grants[$];
  bit       act[2], just[2];
  int       ack_e[2];
  int       cpu_acks = 0, dma_acks = 0, rd_cnt = 0, wr_cnt = 0;

  task automatic cycle();
    int en;
    int d;
    bit rd_e, wr_e, busy_e, ca, da;
    en = e + 1;
    if (reset) begin
      m_act = 0; m_last = 1; m_owner = 0; m_maddr = 0; m_mwd = 0; m_crd = 0; m_drd = 0;
    end else begin
      if (m_act && en >= m_g + L + 2) m_act = 0;
      if (!m_act && (req[0] || req[1])) begin
        if (req[0] && req[1]) begin
`ifdef CPU_PRIORITY_EN
          m_win = 1'b0;
`else
          m_win = !m_last;
`endif
        end else begin
          m_win = req[1];
        end
        m_act = 1; m_g = en; m_last = m_win; m_owner = m_win;
        m_we = we[m_win]; m_maddr = addr[m_win]; m_mwd = wd[m_win];
        if (m_we) ref_mem[m_maddr] = m_mwd;
        else      m_rexp = ref_mem[m_maddr];
        grants.push_back(m_win);
      end
    end
    @(posedge clk);
    #1;
    e = en;
    rd_e = 0; wr_e = 0; busy_e = 0; ca = 0; da = 0;
    for (int i = 0; i < 2; i++) just[i] = 0;
    if (m_act) begin
      d = e - m_g;
      if (d < L) begin
        rd_e = !m_we; wr_e = m_we; busy_e = 1;
      end else if (d == L) begin
        busy_e = 1;
        if (m_win) da = 1; else ca = 1;
        if (!m_we) begin
          if (m_win) m_drd = m_rexp; else m_crd = m_rexp;
        end
        act[m_win] = 0; req[m_win] = 0; just[m_win] = 1; ack_e[m_win] = e;
      end
    end
    cpu_acks += int'(cpu_ack);
    dma_acks += int'(dma_ack);
    rd_cnt   += int'(mem_rd);
    wr_cnt   += int'(mem_wr);
    check("ctl", {mem_rd, mem_wr, busy, cpu_ack, dma_ack, owner}, {rd_e, wr_e, busy_e, ca, da, m_owner});
    check("excl", 32'(mem_rd & mem_wr), 32'd0);
    check("mbus", {mem_addr, mem_wdata}, {m_maddr, m_mwd});
    check("rdata", {cpu_rdata, dma_rdata}, {m_crd, m_drd});
  endtask

  task automatic issue(input int i, input bit w, input logic [7:0] a, input logic [7:0] dt);
    act[i] = 1; req[i] = 1; we[i] = w; addr[i] = a; wd[i] = dt;
  endtask

  task automatic clear_drivers();
    for (int i = 0; i < 2; i++) begin
      act[i] = 0; req[i] = 0; just[i] = 0;
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1;
    clear_drivers();
    repeat (n) cycle();
    reset = 0;
  endtask

  task automatic run_idle(input string tag, input int bound);
    int n = 0;
    while ((act[0] || act[1]) && n < bound) begin
      cycle();
      n++;
    end
    check(tag, 32'(act[0] | act[1]), 32'd0);
  endtask

  initial begin
    int t0, c0, g0, n;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'hB5;
    for (int i = 0; i < 2; i++) begin
      req[i] = 0; we[i] = 0; addr[i] = 0; wd[i] = 0; act[i] = 0; just[i] = 0; ack_e[i] = 0;
    end

    // Reset state: every output 0.
    do_reset(3);
    check("rst_outs", {cpu_ack, dma_ack, mem_rd, mem_wr, busy, owner, cpu_rdata, dma_rdata}, 32'd0);

    // CPU read of 0x10 returning 0xA5.
    rd_cnt = 0; t0 = e;
    issue(0, 0, 8'h10, 8'h00);
    run_idle("t1_timeout", 20);
    check("t1_rdcyc", rd_cnt, L);
    check("t1_lat", ack_e[0] - t0, L + 1);
    check("t1_rdata", cpu_rdata, 8'hA5);
    check("t1_dma_ack", dma_acks, 0);

    // DMA write 0x3C to 0x20.
    wr_cnt = 0; rd_cnt = 0;
    issue(1, 1, 8'h20, 8'h3C);
    run_idle("t2_timeout", 20);
    check("t2_wrcyc", wr_cnt, L);
    check("t2_rdcyc", rd_cnt, 0);
    check("t2_mem", mem[8'h20], 8'h3C);
    check("t2_dma_ack", dma_acks, 1);

    // Simultaneous requests after reset, then both held continuously.
    do_reset(2);
    grants.delete();
    issue(0, 0, 8'h01, 8'h00);
    issue(1, 0, 8'h02, 8'h00);
    run_idle("t3_timeout", 40);
    check("t3_first", grants.size() > 0 ? 32'(grants[0]) : 32'd9, 32'd0);
    check("t3_second", grants.size() > 1 ? 32'(grants[1]) : 32'd9, 32'd1);
    grants.delete();
    n = 0;
    while (grants.size() < 4 && n < 200) begin
      for (int i = 0; i < 2; i++)
        if (!act[i] && !just[i]) issue(i, 0, 8'($urandom_range(0, 255)), 8'h00);
      cycle();
      n++;
    end
    for (int k = 0; k < 4; k++) begin
`ifdef CPU_PRIORITY_EN
      check("t3_owner", grants.size() > k ? 32'(grants[k]) : 32'd9, 32'd0);
`else
      check("t3_owner", grants.size() > k ? 32'(grants[k]) : 32'd9, 32'(k % 2));
`endif
    end
    run_idle("t3_drain", 60);

    // Reset in the second ACCESS cycle of a DMA write, then a fresh CPU read.
    issue(1, 1, 8'h30, 8'h77);
    n = 0;
    while (!(m_act && e - m_g == 1) && n < 20) begin
      cycle();
      n++;
    end
    c0 = dma_acks;
    reset = 1;
    clear_drivers();
    cycle();
    check("t4_rst", {mem_wr, mem_rd, busy, dma_ack}, 32'd0);
    reset = 0;
    cycle();
    cycle();
    check("t4_noack", dma_acks, c0);
    issue(0, 0, 8'h30, 8'h00);
    run_idle("t4_timeout", 20);
    check("t4_rdata", cpu_rdata, 8'h77);

    // CPU drops cpu_req in the first ACCESS cycle.
    c0 = cpu_acks;
    issue(0, 0, 8'h40, 8'h00);
    n = 0;
    while (!(m_act && m_win == 0 && e == m_g) && n < 20) begin
      cycle();
      n++;
    end
    req[0] = 0;
    run_idle("t5_timeout", 20);
    g0 = grants.size();
    repeat (6) cycle();
    check("t5_acks", cpu_acks - c0, 1);
    check("t5_nogrant", grants.size(), g0);

    // Randomized traffic with occasional mid-access drops and resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        reset = 1;
        clear_drivers();
        cycle();
        reset = 0;
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (!act[i] && !just[i] && $urandom_range(0, 3) == 0)
            issue(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
          else if (act[i] && req[i] && m_act && m_win == 1'(i) && e - m_g < L && $urandom_range(0, 5) == 0)
            req[i] = 0;
        end
        cycle();
      end
    end
    clear_drivers();
    repeat (L + 3) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
